dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 90 +++++++++
 tb/tb_dm_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Single-port 16-bit data-memory responder: accepts one request at a time and
// answers with a one-cycle strobe after WAIT_CYCLES wait states.
module dm_responder #(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;

  logic [15:0] mem [2**AW];

  logic          accept;
  logic          in_range;
  logic [15:0]   addr_hi;
  logic [AW-1:0] idx;

  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  // Unsigned: any bit above the implemented range makes the access an error.
  assign addr_hi   = req_addr >> AW;
  assign in_range  = (addr_hi == 16'h0000);
  assign idx       = req_addr[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d  = !in_range;
          data_d = (!req_we && in_range) ? mem[idx] : 16'h0000;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Memory is never reset; a write commits at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) mem[idx] <= req_wdata;
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? data_q : 16'h0000;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed scoreboard bench: three responders (WAIT_CYCLES 1, 0, 3) sharing a clock.
module tb_dm_responder;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  localparam int WC [3] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        vld   [3];
  logic        rdy   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        rv    [3];
  logic [15:0] rd    [3];
  logic        re    [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e0     [3];
  logic [15:0] mdl [3][256];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder #(.AW(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(rst_n[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));
  dm_responder #(.AW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst_n[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));
  dm_responder #(.AW(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst_n[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(we[2]), .req_addr(addr[2]), .req_wdata(wdata[2]),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected response, present the request and return at the negedge after E0.
  // With hold set, req_valid stays high and the payload is scrambled while waiting.
  task automatic issue(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit hold);
    exp_t e;
    int   n;
    e.err   = (a[15:8] != 8'h00);
    e.rdata = (!w && !e.err) ? mdl[k][a[7:0]] : 16'h0000;
    if (w && !e.err) mdl[k][a[7:0]] = d;
    sbq.push_back(e);
    vld[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    n = 0;
    while (!rdy[k] && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 30), 32'd1);
    @(posedge clk);
    @(negedge clk);
    e0[k] = cyc;
    if (hold) begin
      we[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
    end else begin
      vld[k] = 1'b0;
    end
  endtask

  // Called at the negedge after E0; returns at the negedge of the response cycle.
  task automatic wait_rsp(input int k);
    exp_t e;
    int   n;
    n = 1;
    while (!rv[k] && n < 40) begin
      chk("idle_rdata", 32'(rd[k]), 32'd0);
      chk("idle_err", 32'(re[k]), 32'd0);
      chk("busy_ready", 32'(rdy[k]), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(WC[k] + 1));
    chk("rsp_ready_low", 32'(rdy[k]), 32'd0);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("rsp_rdata", 32'(rd[k]), 32'(e.rdata));
      chk("rsp_err", 32'(re[k]), 32'(e.err));
    end
  endtask

  task automatic xact(input int k, input bit w, input logic [15:0] a, input logic [15:0] d);
    issue(k, w, a, d, 1'b0);
    wait_rsp(k);
    @(negedge clk);
    chk("strobe_one_cycle", 32'(rv[k]), 32'd0);
    chk("ready_back", 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; vld[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(rv[k]), 32'd0);
      chk("rst_rdata", 32'(rd[k]), 32'd0);
      chk("rst_err", 32'(re[k]), 32'd0);
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++) chk("ready_after_rst", 32'(rdy[k]), 32'd1);
    @(negedge clk);

    // Write then read, one wait state.
    xact(0, 1'b1, 16'h0012, 16'hA5C3);
    xact(0, 1'b0, 16'h0012, 16'h0000);

    // Out-of-range accesses leave memory untouched.
    xact(0, 1'b1, 16'h0000, 16'h5A5A);
    xact(0, 1'b1, 16'h0100, 16'h1234);
    xact(0, 1'b0, 16'h0000, 16'h0000);
    xact(0, 1'b0, 16'h0100, 16'h0000);
    xact(0, 1'b0, 16'hFFFF, 16'h0000);

    // Boundary address and memory retention across reset.
    xact(0, 1'b1, 16'h00FF, 16'h1357);
    xact(0, 1'b0, 16'h00FF, 16'h0000);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    xact(0, 1'b0, 16'h00FF, 16'h0000);
    xact(0, 1'b0, 16'h0012, 16'h0000);

    // Zero wait: back-to-back held requests every 2 cycles.
    xact(1, 1'b1, 16'h0040, 16'hC0DE);
    issue(1, 1'b0, 16'h0040, 16'h0000, 1'b1);
    t0 = e0[1];
    wait_rsp(1);
    issue(1, 1'b1, 16'h0041, 16'h7777, 1'b1);
    chk("w0_spacing", 32'(e0[1] - t0), 32'd2);
    t0 = e0[1];
    wait_rsp(1);
    issue(1, 1'b0, 16'h0041, 16'h0000, 1'b0);
    chk("w0_spacing2", 32'(e0[1] - t0), 32'd2);
    wait_rsp(1);
    @(negedge clk);
    chk("w0_ready_back", 32'(rdy[1]), 32'd1);

    // Three wait states: inputs scrambled and valid held while busy.
    xact(2, 1'b1, 16'h0033, 16'h4242);
    issue(2, 1'b0, 16'h0033, 16'h0000, 1'b1);
    t0 = e0[2];
    wait_rsp(2);
    issue(2, 1'b0, 16'h0012, 16'h0000, 1'b0);
    chk("w3_spacing", 32'(e0[2] - t0), 32'd5);
    wait_rsp(2);
    @(negedge clk);

    // Reset during WAIT: write persists, response is dropped.
    issue(2, 1'b1, 16'h0005, 16'hBEEF, 1'b0);
    void'(sbq.pop_back());
    rst_n[2] = 1'b0;
    #1;
    chk("rst_ready_comb", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    chk("midrst_valid", 32'(rv[2]), 32'd0);
    chk("midrst_rdata", 32'(rd[2]), 32'd0);
    chk("midrst_err", 32'(re[2]), 32'd0);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped_rsp", 32'(rv[2]), 32'd0);
      chk("idle_ready", 32'(rdy[2]), 32'd1);
    end
    xact(2, 1'b0, 16'h0005, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
